// File: rtl/ram_stream.sv
// ram_stream -- streaming-load block RAM with an independent read port.
//
// A write stream fills the memory from address 0 upward after each wr_start
// pulse. Once WORDS beats have been accepted the block stops accepting beats
// and holds wr_done until the next wr_start. The read port works every cycle
// in every state and returns read-first data with a latency of RD_LAT (1 or 2).
//
// Ports:
//   clk       sole clock, everything on posedge
//   rst       synchronous active-high reset (memory contents are kept)
//   wr_start  pulse: rewind write pointer and (re)enter load mode
//   wr_valid  wr_data carries a beat
//   wr_data   write beat
//   wr_ready  registered: block accepts a beat this cycle
//   wr_done   registered level: all WORDS locations loaded since last wr_start
//   wr_count  beats accepted since last wr_start
//   rd_en     read request
//   rd_addr   read address (addresses >= WORDS read as zero)
//   rd_data   registered read data, holds while rd_valid is low
//   rd_valid  rd_data is valid, exactly RD_LAT cycles after rd_en

`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module ram_stream #(
  parameter int DWIDTH = `DATA_LEN,
  parameter int AWIDTH = 12,
  parameter int WORDS  = 12 * 288,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_start,
  input  logic              wr_valid,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_done,
  output logic [AWIDTH:0]   wr_count,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(WORDS - 1);
  localparam logic [AWIDTH:0]   WORDS_CNT = (AWIDTH + 1)'(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL
  } state_t;

  state_t            state, state_next;
  logic [AWIDTH-1:0] wptr, wptr_next;
  logic [AWIDTH:0]   count_next;
  logic              wr_fire;

  (* ram_style = "block" *) logic [DWIDTH-1:0] mem [WORDS];

  // ---------------------------------------------------------------------------
  // Load FSM: next-state and write-side bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_next = state;
    wptr_next  = wptr;
    count_next = wr_count;
    wr_fire    = 1'b0;

    unique case (state)
      IDLE: begin
        if (wr_start) begin
          state_next = LOAD;
          wptr_next  = '0;
          count_next = '0;
        end
      end

      LOAD: begin
        if (wr_start) begin
          // Restart wins over a beat presented in the same cycle; the beat
          // is dropped rather than written at the old pointer.
          wptr_next  = '0;
          count_next = '0;
        end else if (wr_valid && wr_ready) begin
          wr_fire    = 1'b1;
          count_next = wr_count + (AWIDTH + 1)'(1);
          if (wptr == LAST_ADDR) begin
            // Pointer parks on the last address instead of wrapping.
            state_next = FULL;
          end else begin
            wptr_next = wptr + AWIDTH'(1);
          end
        end
      end

      FULL: begin
        if (wr_start) begin
          state_next = LOAD;
          wptr_next  = '0;
          count_next = '0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // wr_ready / wr_done are registered decodes of the next state, so neither
  // has a combinational path from wr_valid or wr_start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      wptr     <= '0;
      wr_count <= '0;
      wr_ready <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      state    <= state_next;
      wptr     <= wptr_next;
      wr_count <= count_next;
      wr_ready <= (state_next == LOAD);
      wr_done  <= (state_next == FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset; clearing it would prevent block RAM
  // mapping, and loaded data must survive rst anyway.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      mem[wptr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  // Out-of-range addresses still access a legal location (index 0) so the
  // array is never indexed past its end; the in-range flag travels with the
  // request and forces the returned word to zero.
  logic              rd_in_range;
  logic [AWIDTH-1:0] rd_idx;

  assign rd_in_range = ({1'b0, rd_addr} < WORDS_CNT);
  assign rd_idx      = rd_in_range ? rd_addr : '0;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DWIDTH-1:0] ram_q;
      logic              s1_valid;
      logic              s1_in_range;

      // Raw RAM output register; read-first because the write to the same
      // location lands at the same edge.
      always_ff @(posedge clk) begin
        if (rd_en) begin
          ram_q <= mem[rd_idx];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid    <= 1'b0;
          s1_in_range <= 1'b0;
        end else begin
          s1_valid <= rd_en;
          if (rd_en) begin
            s1_in_range <= rd_in_range;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= s1_valid;
          if (s1_valid) begin
            rd_data <= s1_in_range ? ram_q : '0;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= rd_en;
          if (rd_en) begin
            rd_data <= rd_in_range ? mem[rd_idx] : '0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_stream.sv
// Directed bench for ram_stream. Two instances (RD_LAT=1 and RD_LAT=2) share
// every input so each read is checked at both latencies in the same run.

module tb_ram_stream;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int WORDS = 3456;

  logic          clk;
  logic          rst;
  logic          wr_start;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic          wr_ready1, wr_done1, rd_valid1;
  logic [AW:0]   wr_count1;
  logic [DW-1:0] rd_data1;
  logic          wr_ready2, wr_done2, rd_valid2;
  logic [AW:0]   wr_count2;
  logic [DW-1:0] rd_data2;

  int checks = 0;
  int errors = 0;

  ram_stream #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(WORDS), .RD_LAT(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .wr_start (wr_start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready1),
    .wr_done  (wr_done1),
    .wr_count (wr_count1),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data1),
    .rd_valid (rd_valid1)
  );

  ram_stream #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(WORDS), .RD_LAT(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .wr_start (wr_start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready2),
    .wr_done  (wr_done2),
    .wr_count (wr_count2),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data2),
    .rd_valid (rd_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge that updated them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic rdy, input logic done, input int cnt);
    check({tag, ".ready1"}, 32'(wr_ready1), 32'(rdy));
    check({tag, ".done1"},  32'(wr_done1),  32'(done));
    check({tag, ".count1"}, 32'(wr_count1), 32'(cnt));
    check({tag, ".ready2"}, 32'(wr_ready2), 32'(rdy));
    check({tag, ".done2"},  32'(wr_done2),  32'(done));
    check({tag, ".count2"}, 32'(wr_count2), 32'(cnt));
  endtask

  task automatic chk_r1(input string tag, input logic v, input logic [DW-1:0] d);
    check({tag, ".valid1"}, 32'(rd_valid1), 32'(v));
    check({tag, ".data1"},  32'(rd_data1),  32'(d));
  endtask

  task automatic chk_r2(input string tag, input logic v, input logic [DW-1:0] d);
    check({tag, ".valid2"}, 32'(rd_valid2), 32'(v));
    check({tag, ".data2"},  32'(rd_data2),  32'(d));
  endtask

  // Single isolated read: checks valid timing at N+1 and N+2 for both
  // latencies, and that the RD_LAT=1 output holds its data afterwards.
  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk_r1({tag, "@N+1"}, 1'b1, e);
    check({tag, "@N+1.valid2"}, 32'(rd_valid2), 32'd0);
    tick();
    chk_r1({tag, "@N+2"}, 1'b0, e);
    chk_r2({tag, "@N+2"}, 1'b1, e);
    tick();
    check({tag, "@N+3.valid2"}, 32'(rd_valid2), 32'd0);
  endtask

  task automatic stream(input int first, input int last, input logic [DW-1:0] base);
    wr_valid = 1'b1;
    for (int i = first; i <= last; i++) begin
      wr_data = base + DW'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    wr_start = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_wr("reset", 1'b0, 1'b0, 0);
    chk_r1("reset", 1'b0, 16'h0000);
    chk_r2("reset", 1'b0, 16'h0000);

    // Full load d=i
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    chk_wr("start", 1'b1, 1'b0, 0);

    wr_valid = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      wr_data = DW'(i);
      tick();
      check("load.count", 32'(wr_count1), 32'(i + 1));
      if (i == WORDS - 2) chk_wr("load.penult", 1'b1, 1'b0, WORDS - 1);
    end
    chk_wr("full", 1'b0, 1'b1, WORDS);
    // Extra beat in FULL is ignored
    wr_data = 16'hFFFF;
    tick();
    wr_valid = 1'b0;
    chk_wr("full.ignore", 1'b0, 1'b1, WORDS);

    // Back-to-back readback of the whole array
    for (int i = 0; i < WORDS; i++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(i);
      tick();
      chk_r1("bulk", 1'b1, DW'(i));
      if (i > 0) chk_r2("bulk", 1'b1, DW'(i - 1));
      else check("bulk.first.valid2", 32'(rd_valid2), 32'd0);
    end
    rd_en = 1'b0;
    tick();
    chk_r1("bulk.tail", 1'b0, DW'(WORDS - 1));
    chk_r2("bulk.tail", 1'b1, DW'(WORDS - 1));
    tick();
    chk_r2("bulk.idle", 1'b0, DW'(WORDS - 1));

    // Latency at addr 5 and out-of-range address
    do_read("rd5", 12'd5, 16'd5);
    do_read("oob", 12'd4095, 16'h0000);

    // Reload from FULL; read-first collision at addr 7
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    chk_wr("restart.full", 1'b1, 1'b0, 0);
    stream(0, 6, 16'h0000);
    wr_valid = 1'b1;
    wr_data  = 16'h00AA;
    rd_en    = 1'b1;
    rd_addr  = 12'd7;
    tick();
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    chk_r1("rmw.old", 1'b1, 16'd7);
    chk_wr("rmw", 1'b1, 1'b0, 8);
    tick();
    chk_r2("rmw.old", 1'b1, 16'd7);
    do_read("rmw.new", 12'd7, 16'h00AA);

    // Restart in LOAD at wr_count=100 drops the simultaneous beat
    stream(8, 99, 16'h0000);
    chk_wr("cnt100", 1'b1, 1'b0, 100);
    wr_start = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 16'h0055;
    tick();
    wr_start = 1'b0;
    chk_wr("restart.load", 1'b1, 1'b0, 0);
    wr_data = 16'h1234;
    tick();
    wr_valid = 1'b0;
    chk_wr("after.restart", 1'b1, 1'b0, 1);
    do_read("addr0.new", 12'd0, 16'h1234);
    do_read("addr100.kept", 12'd100, 16'd100);

    // Reset mid-load at wr_count=50 with read, beat and wr_start pending
    stream(1, 49, 16'h0100);
    chk_wr("cnt50", 1'b1, 1'b0, 50);
    rst      = 1'b1;
    wr_start = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 16'hBEEF;
    rd_en    = 1'b1;
    rd_addr  = 12'd3;
    tick();
    rst      = 1'b0;
    wr_start = 1'b0;
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    chk_wr("rst.mid", 1'b0, 1'b0, 0);
    chk_r1("rst.mid", 1'b0, 16'h0000);
    chk_r2("rst.mid", 1'b0, 16'h0000);
    tick();
    chk_r2("rst.discard", 1'b0, 16'h0000);
    chk_wr("rst.idle", 1'b0, 1'b0, 0);

    // Beats in IDLE are ignored
    wr_valid = 1'b1;
    wr_data  = 16'h0001;
    tick();
    wr_valid = 1'b0;
    chk_wr("idle.ignore", 1'b0, 1'b0, 0);

    do_read("keep0", 12'd0, 16'h1234);
    do_read("keep1", 12'd1, 16'h0101);
    do_read("keep49", 12'd49, 16'h0131);
    do_read("keep50", 12'd50, 16'd50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_stream.md
RAM_STREAM -- requirements
Module: ram_stream

Interface
REQ-001 Parameter DWIDTH, default `data_len, data word width in bits.
REQ-002 Parameter AWIDTH, default 12, address width in bits.
REQ-003 Parameter WORDS, default 12*288 (3456), memory depth; SHALL satisfy WORDS <= 2^AWIDTH.
REQ-004 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 clk  input  1  sole clock; all logic on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_start  input  1  pulse: rewind write pointer, enter load mode.
REQ-008 wr_valid  input  1  wr_data holds a valid beat.
REQ-009 wr_data  input  DWIDTH  write beat.
REQ-010 wr_ready  output  1  block accepts a beat this cycle.
REQ-011 wr_done  output  1  level: all WORDS locations loaded since last wr_start.
REQ-012 wr_count  output  AWIDTH+1  number of beats accepted since last wr_start.
REQ-013 rd_en  input  1  read request.
REQ-014 rd_addr  input  AWIDTH  read address.
REQ-015 rd_data  output  DWIDTH  registered read data.
REQ-016 rd_valid  output  1  rd_data valid this cycle.

Function
REQ-017 Storage SHALL be one WORDS x DWIDTH array with ram_style "block", one write port, one independent read port.
REQ-018 FSM SHALL have states IDLE, LOAD, FULL.
REQ-019 IDLE: wr_ready=0, wr_done=0; wr_start -> LOAD with write pointer=0, wr_count=0.
REQ-020 LOAD: wr_ready=1; beat accepted when wr_valid&&wr_ready; accepted beat written to mem[wptr], wptr and wr_count increment by 1.
REQ-021 LOAD: acceptance of beat at wptr==WORDS-1 -> FULL next cycle; wptr never wraps.
REQ-022 FULL: wr_ready=0, wr_done=1, wr_count=WORDS; wr_valid ignored; wr_start -> LOAD with wptr=0, wr_count=0, wr_done=0 next cycle.
REQ-023 wr_start asserted in LOAD SHALL restart (wptr=0, wr_count=0); a simultaneous wr_valid beat is dropped and not written.
REQ-024 wr_ready SHALL be a registered function of state only (no combinational path from wr_valid).
REQ-025 Reads SHALL be accepted in every state, every cycle, independent of write activity.
REQ-026 RD_LAT=1: rd_en in cycle N -> rd_data/rd_valid in N+1; RD_LAT=2: adds one output register, result in N+2; back-to-back reads at full rate.
REQ-027 rd_valid SHALL be 1 exactly RD_LAT cycles after each rd_en, otherwise 0; rd_data holds last value when rd_valid=0.
REQ-028 Read and write to same address in same cycle SHALL return the old contents (read-first).
REQ-029 rd_addr >= WORDS SHALL return rd_data=0 with rd_valid asserted normally; no memory access side effect.

Reset
REQ-030 rst SHALL force state IDLE, wptr=0, wr_count=0, wr_ready=0, wr_done=0, rd_valid pipeline=0, rd_data=0 on the next edge.
REQ-031 Memory contents SHALL NOT be cleared by rst.
REQ-032 rst SHALL take priority over wr_start, wr_valid and rd_en in the same cycle; in-flight reads are discarded.
REQ-033 rst mid-LOAD SHALL abandon the load; already-written words remain readable.

Verification
REQ-034 rst, wr_start, stream 3456 beats d=i with wr_valid=1 -> wr_ready drops after beat 3456, wr_done=1, wr_count=3456; reads 0..3455 return i.
REQ-035 RD_LAT=1 and RD_LAT=2 builds: rd_en at addr 5 in cycle N -> rd_valid=1, rd_data=5 at N+1 / N+2; no rd_valid otherwise.
REQ-036 Same-cycle write 0xAA to addr 7 (old 7) and read addr 7 -> rd_data=7; next read -> 0xAA.
REQ-037 wr_start at wr_count=100 with wr_valid=1 -> beat dropped, wr_count=0; next beat lands at addr 0.
REQ-038 rst asserted at wr_count=50 with rd_en pending -> next cycle all outputs at reset values, rd_valid=0; addr 0..49 still readable with loaded data.
REQ-039 rd_addr=4095 (>= WORDS) -> rd_valid=1, rd_data=0.
